// File: rtl/axis_packet_dispatcher_scheduler.sv
// Packet dispatcher: hands header beats to a parser, then forwards analysed
// beats and the packet remainder, or drops the packet on parser request/timeout.
module axis_packet_dispatcher_scheduler #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int PARSE_BEATS = 2,
    parameter int CONTROL_TIMEOUT = 255,
    parameter int STATE_WIDTH = 3,
    parameter logic [STATE_WIDTH-1:0] IDLE = STATE_WIDTH'(0),
    parameter logic [STATE_WIDTH-1:0] PARSE_DATA = STATE_WIDTH'(1),
    parameter logic [STATE_WIDTH-1:0] CONTROL = STATE_WIDTH'(2),
    parameter logic [STATE_WIDTH-1:0] SEND_ANALYSED_DATA = STATE_WIDTH'(3),
    parameter logic [STATE_WIDTH-1:0] SEND_REMAIN = STATE_WIDTH'(4),
    parameter logic [STATE_WIDTH-1:0] DROP = STATE_WIDTH'(5)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       parser_load,
    input  logic                       parser_done,
    input  logic                       parser_drop,
    output logic                       parser_rd,
    output logic [STATE_WIDTH-1:0]     state,
    output logic [31:0]                pkt_count,
    output logic [31:0]                drop_count
);

    logic [3:0]                 hdr_cnt;
    logic [3:0]                 out_cnt;
    logic [15:0]                timer;
    logic                       short_pkt;
    logic [AXIS_KEEP_WIDTH-1:0] short_keep;

    logic s_hs;
    logic m_hs;
    logic hdr_full;
    logic last_analysed;
    logic timeout_hit;

    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign m_hs = m_axis_tvalid & m_axis_tready;
    assign hdr_full = (hdr_cnt + 4'd1) == 4'(PARSE_BEATS);
    assign last_analysed = out_cnt == (hdr_cnt - 4'd1);
    assign timeout_hit = timer == 16'(CONTROL_TIMEOUT - 1);

    // Outputs decode the state register; SEND_REMAIN is a pure pass-through.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tkeep = '0;
        m_axis_tlast = 1'b0;
        parser_load = 1'b0;
        parser_rd = 1'b0;
        unique case (state)
            PARSE_DATA: begin
                s_axis_tready = 1'b1;
                parser_load = s_axis_tvalid;
            end
            SEND_ANALYSED_DATA: begin
                m_axis_tvalid = 1'b1;
                parser_rd = m_axis_tready;
                if (short_pkt && last_analysed) begin
                    m_axis_tkeep = short_keep;
                    m_axis_tlast = 1'b1;
                end else begin
                    m_axis_tkeep = '1;
                end
            end
            SEND_REMAIN: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tkeep = s_axis_tkeep;
                m_axis_tlast = s_axis_tlast;
            end
            DROP: begin
                s_axis_tready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hdr_cnt <= '0;
            out_cnt <= '0;
            timer <= '0;
            short_pkt <= 1'b0;
            short_keep <= '0;
            pkt_count <= '0;
            drop_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    hdr_cnt <= '0;
                    out_cnt <= '0;
                    timer <= '0;
                    short_pkt <= 1'b0;
                    if (s_axis_tvalid) begin
                        state <= PARSE_DATA;
                    end
                end
                PARSE_DATA: begin
                    if (s_hs) begin
                        hdr_cnt <= hdr_cnt + 4'd1;
                        if (s_axis_tlast) begin
                            short_pkt <= 1'b1;
                            short_keep <= s_axis_tkeep;
                        end
                        if (s_axis_tlast || hdr_full) begin
                            state <= CONTROL;
                            timer <= '0;
                            pkt_count <= pkt_count + 32'd1;
                        end
                    end
                end
                CONTROL: begin
                    timer <= timer + 16'd1;
                    out_cnt <= '0;
                    // A parser answer in the expiry cycle takes priority.
                    if (parser_done && !parser_drop) begin
                        state <= SEND_ANALYSED_DATA;
                    end else if (parser_done || timeout_hit) begin
                        drop_count <= drop_count + 32'd1;
                        state <= short_pkt ? IDLE : DROP;
                    end
                end
                SEND_ANALYSED_DATA: begin
                    if (m_hs) begin
                        out_cnt <= out_cnt + 4'd1;
                        if (last_analysed) begin
                            state <= short_pkt ? IDLE : SEND_REMAIN;
                        end
                    end
                end
                SEND_REMAIN: begin
                    if (s_hs && s_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (s_hs && s_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_dispatcher_scheduler.sv
// Randomised bench for the packet dispatcher against a packet-level model
// of which beats must leave the block and how the counters advance.
module tb_axis_packet_dispatcher_scheduler;

    localparam int PB = 2;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        parser_load;
    logic        parser_done = 1'b0;
    logic        parser_drop = 1'b0;
    logic        parser_rd;
    logic [2:0]  state;
    logic [31:0] pkt_count;
    logic [31:0] drop_count;

    axis_packet_dispatcher_scheduler #(
        .AXIS_DATA_WIDTH(64),
        .PARSE_BEATS(PB),
        .CONTROL_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .parser_load(parser_load),
        .parser_done(parser_done),
        .parser_drop(parser_drop),
        .parser_rd(parser_rd),
        .state(state),
        .pkt_count(pkt_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // stimulus controls
    int   done_at = 0;
    logic drop_sel = 1'b0;
    int   ctl_seen = 0;
    int   rmode = 0;
    logic [7:0] pkt_keep [16];

    // observations
    logic [8:0] got_q[$];
    int n_load, n_rd, n_ctl, n_mvalid, stall_err;
    logic [31:0] obs_seq;
    logic [2:0]  last_st;
    logic prev_stall = 1'b0;
    logic [7:0] prev_keep;
    logic prev_last;

    // model outputs
    logic [8:0] exp_q[$];
    logic m_acc;
    int m_load, m_rd, m_ctl;
    logic [31:0] m_seq;
    int exp_pkts = 0;
    int exp_drops = 0;

    // parser answers on a chosen CONTROL cycle (0 = never)
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (state == 3'd2) ctl_seen = ctl_seen + 1;
            else ctl_seen = 0;
            parser_done = (state == 3'd2) && (ctl_seen == done_at);
            parser_drop = drop_sel;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !(m_axis_tvalid && m_axis_tkeep == prev_keep
                                    && m_axis_tlast == prev_last))
                    stall_err++;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_keep = m_axis_tkeep;
                prev_last = m_axis_tlast;
                if (m_axis_tvalid && m_axis_tready)
                    got_q.push_back({m_axis_tlast, m_axis_tkeep});
                if (m_axis_tvalid) n_mvalid++;
                if (parser_load) n_load++;
                if (parser_rd) n_rd++;
                if (state == 3'd2) n_ctl++;
                if (state != last_st) begin
                    obs_seq = (obs_seq << 4) | 32'(state);
                    last_st = state;
                end
            end
        end
    end

    function automatic void clear_obs();
        got_q.delete();
        n_load = 0;
        n_rd = 0;
        n_ctl = 0;
        n_mvalid = 0;
        stall_err = 0;
        obs_seq = 32'(state);
        last_st = state;
    endfunction

    // Packet-level rules: header beats become analysed beats, rest pass through.
    function automatic void model(input int n, input int d, input logic drp);
        logic sh;
        logic l;
        int hdr;
        sh = n <= PB;
        hdr = (n < PB) ? n : PB;
        m_acc = (d >= 1) && (d <= TMO) && !drp;
        m_ctl = ((d >= 1) && (d <= TMO)) ? d : TMO;
        m_load = hdr;
        m_rd = m_acc ? hdr : 0;
        exp_pkts++;
        if (!m_acc) exp_drops++;
        if (m_acc) m_seq = sh ? 32'h01230 : 32'h012340;
        else m_seq = sh ? 32'h0120 : 32'h01250;
        exp_q.delete();
        if (m_acc) begin
            for (int i = 0; i < n; i++) begin
                l = (i == n - 1);
                if (i < hdr)
                    exp_q.push_back({sh && l, (sh && l) ? pkt_keep[i] : 8'hFF});
                else
                    exp_q.push_back({l, pkt_keep[i]});
            end
        end
    endfunction

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic send_beat(input logic [7:0] k, input logic l, input int gap);
        int w;
        repeat (gap) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tkeep = k;
        s_axis_tlast = l;
        w = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            w++;
            if (w > 200) begin
                total++;
                bad++;
                $display("FAIL beat_accept: tready low for %0d cycles, required accept", w);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (state != 3'd0 && w < 300);
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL idle_return: state=%0d required=0", state);
        end
    endtask

    task automatic play_pkt(input int n, input int d, input logic drp, input int gapmax);
        done_at = d;
        drop_sel = drp;
        clear_obs();
        for (int i = 0; i < n; i++)
            send_beat(pkt_keep[i], i == n - 1, $urandom_range(0, gapmax));
        wait_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: got=%0d required=0", state);
        end
        total++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, parser_load, parser_rd,
             m_axis_tkeep} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got=%b required=0", {s_axis_tready,
                     m_axis_tvalid, m_axis_tlast, parser_load, parser_rd, m_axis_tkeep});
        end
        total++;
        if (pkt_count !== 32'd0 || drop_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_counts: got=%0d/%0d required=0/0", pkt_count, drop_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pkts = 0;
        exp_drops = 0;
    endtask

    task automatic test_forward();
        rmode = 0;
        for (int i = 0; i < 5; i++) pkt_keep[i] = 8'($urandom);
        model(5, 3, 1'b0);
        play_pkt(5, 3, 1'b0, 0);
        total++;
        if (obs_seq !== 32'h012340) begin
            bad++;
            $display("FAIL fwd_states: got=%h required=012340", obs_seq);
        end
        total++;
        if (n_load !== 2 || n_rd !== 2) begin
            bad++;
            $display("FAIL fwd_parser: load=%0d rd=%0d required=2/2", n_load, n_rd);
        end
        total++;
        if (first_diff() != -1) begin
            bad++;
            $display("FAIL fwd_beats: diff=%0d got_n=%0d required_n=5", first_diff(), got_q.size());
        end
        total++;
        if (pkt_count !== 32'd1 || drop_count !== 32'd0) begin
            bad++;
            $display("FAIL fwd_counts: got=%0d/%0d required=1/0", pkt_count, drop_count);
        end
    endtask

    task automatic test_drop();
        model(5, 3, 1'b1);
        play_pkt(5, 3, 1'b1, 1);
        total++;
        if (obs_seq !== 32'h01250) begin
            bad++;
            $display("FAIL drop_states: got=%h required=01250", obs_seq);
        end
        total++;
        if (n_mvalid !== 0 || n_rd !== 0) begin
            bad++;
            $display("FAIL drop_quiet: mvalid=%0d rd=%0d required=0/0", n_mvalid, n_rd);
        end
        total++;
        if (pkt_count !== 32'd2 || drop_count !== 32'd1) begin
            bad++;
            $display("FAIL drop_counts: got=%0d/%0d required=2/1", pkt_count, drop_count);
        end
    endtask

    task automatic test_short();
        pkt_keep[0] = 8'h0F;
        model(1, 2, 1'b0);
        play_pkt(1, 2, 1'b0, 0);
        total++;
        if (got_q.size() != 1 || got_q[0] !== 9'h10F) begin
            bad++;
            $display("FAIL short_beat: got_n=%0d required one beat keep=0f last=1", got_q.size());
        end
        total++;
        if (obs_seq !== 32'h01230) begin
            bad++;
            $display("FAIL short_states: got=%h required=01230", obs_seq);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 3; i++) pkt_keep[i] = 8'($urandom);
        model(3, 0, 1'b0);
        play_pkt(3, 0, 1'b0, 0);
        total++;
        if (n_ctl !== TMO || obs_seq !== 32'h01250) begin
            bad++;
            $display("FAIL tmo_expire: ctl=%0d seq=%h required=4/01250", n_ctl, obs_seq);
        end
        model(3, TMO, 1'b0);
        play_pkt(3, TMO, 1'b0, 0);
        total++;
        if (n_ctl !== TMO || obs_seq !== 32'h012340) begin
            bad++;
            $display("FAIL tmo_last_cycle: ctl=%0d seq=%h required=4/012340", n_ctl, obs_seq);
        end
        total++;
        if (first_diff() != -1) begin
            bad++;
            $display("FAIL tmo_beats: diff=%0d required=-1", first_diff());
        end
    endtask

    task automatic test_stall();
        for (int m = 1; m <= 2; m++) begin
            rmode = m;
            for (int i = 0; i < 6; i++) pkt_keep[i] = 8'($urandom);
            model(6, 1, 1'b0);
            play_pkt(6, 1, 1'b0, 1);
            total++;
            if (first_diff() != -1 || stall_err != 0) begin
                bad++;
                $display("FAIL stall_beats: mode=%0d diff=%0d unstable=%0d required=-1/0",
                         m, first_diff(), stall_err);
            end
        end
        rmode = 0;
    endtask

    task automatic test_random();
        int n, d;
        logic drp;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(1, 6);
            d = $urandom_range(0, TMO + 1);
            drp = 1'($urandom_range(0, 1));
            rmode = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) pkt_keep[i] = 8'($urandom);
            model(n, d, drp);
            play_pkt(n, d, drp, 2);
            total++;
            if (first_diff() != -1 || stall_err != 0) begin
                bad++;
                $display("FAIL rnd_beats: pkt=%0d n=%0d d=%0d drop=%0d diff=%0d unstable=%0d",
                         p, n, d, drp, first_diff(), stall_err);
            end
            total++;
            if (n_load !== m_load || n_rd !== m_rd) begin
                bad++;
                $display("FAIL rnd_parser: pkt=%0d load=%0d rd=%0d required=%0d/%0d",
                         p, n_load, n_rd, m_load, m_rd);
            end
            total++;
            if (obs_seq !== m_seq || n_ctl !== m_ctl) begin
                bad++;
                $display("FAIL rnd_states: pkt=%0d seq=%h ctl=%0d required=%h/%0d",
                         p, obs_seq, n_ctl, m_seq, m_ctl);
            end
        end
        total++;
        if (pkt_count !== 32'(exp_pkts) || drop_count !== 32'(exp_drops)) begin
            bad++;
            $display("FAIL rnd_counts: got=%0d/%0d required=%0d/%0d",
                     pkt_count, drop_count, exp_pkts, exp_drops);
        end
        rmode = 0;
    endtask

    task automatic test_reset_mid();
        int w;
        rmode = 0;
        done_at = 1;
        drop_sel = 1'b0;
        send_beat(8'hFF, 1'b0, 0);
        send_beat(8'hFF, 1'b0, 0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (state != 3'd4 && w < 100);
        total++;
        if (state !== 3'd4) begin
            bad++;
            $display("FAIL rstmid_reach: state=%0d required=4", state);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (state !== 3'd0 || {s_axis_tready, m_axis_tvalid, m_axis_tlast, parser_load,
                               parser_rd, m_axis_tkeep} !== 13'd0) begin
            bad++;
            $display("FAIL rstmid_outputs: state=%0d required=0 with outputs idle", state);
        end
        total++;
        if (pkt_count !== 32'd0 || drop_count !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_counts: got=%0d/%0d required=0/0", pkt_count, drop_count);
        end
        exp_pkts = 0;
        exp_drops = 0;
        // the leftover tail beat starts a fresh packet
        pkt_keep[0] = 8'h03;
        model(1, 1, 1'b0);
        play_pkt(1, 1, 1'b0, 0);
        total++;
        if (first_diff() != -1 || pkt_count !== 32'd1 || obs_seq !== 32'h01230) begin
            bad++;
            $display("FAIL rstmid_newpkt: diff=%0d pkts=%0d seq=%h required=-1/1/01230",
                     first_diff(), pkt_count, obs_seq);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_drop();
        test_short();
        test_timeout();
        test_stall();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
